noc_inject_ni: RTL and testbench

Injection network interface that sits directly upstream of `router_wrap` local port 4. It converts fabric-side words into flits and drives the router's `idata_4`, `ivalid_4`, `ivch_4` and `ilck_4` inputs. Each packet is a generated head flit followed by body/tail flits. Flow control is credit-based, with two virtual channels, using the router's `oack_4` credit returns.

---
 rtl/noc_pkg.sv | 26 ++
 rtl/ni_credit_counter.sv | 31 +++
 rtl/noc_inject_ni.sv | 134 +++++++++++++
 tb/tb_noc_inject_ni.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the NoC injection network interface: flit layout,
// type codes and the injection FSM state encoding.
package noc_pkg;

  localparam int FLIT_W = 35;
  localparam int NUM_VC = 2;

  localparam logic [1:0] FT_HEAD = 2'b10;
  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_TAIL = 2'b01;

  // Offsets into a flit declared [0:FLIT_W-1], bit 0 being the MSB
  localparam int TYPE_OFS  = 0;
  localparam int DST_X_OFS = 2;
  localparam int DST_Y_OFS = 4;
  localparam int SRC_X_OFS = 6;
  localparam int SRC_Y_OFS = 8;
  localparam int DATA_OFS  = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEAD,
    ST_DATA
  } ni_state_t;

endpackage

// File: rtl/ni_credit_counter.sv
// Per-VC credit counter: starts full, consumed by flit sends, refilled by
// router acks; an ack with nothing outstanding raises a sticky overflow.
module ni_credit_counter #(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          overflow
);

  always_ff @(posedge clk) begin
    if (rst_) begin
      count    <= CW'(BUF_DEPTH);
      overflow <= 1'b0;
    end else begin
      case ({dec, inc})
        2'b10:   count <= count - 1'b1;
        2'b01: begin
          if (count == CW'(BUF_DEPTH)) overflow <= 1'b1;
          else                         count    <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/noc_inject_ni.sv
// Injection NI: turns fabric words into head/body/tail flits for router
// local port 4, with two credit-managed virtual channels picked round-robin.
module noc_inject_ni
  import noc_pkg::*;
#(
  parameter int BUF_DEPTH = 4,
  parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [1:0]        my_xpos,
  input  logic [1:0]        my_ypos,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [31:0]       tx_data,
  input  logic              tx_last,
  input  logic [1:0]        tx_dst_x,
  input  logic [1:0]        tx_dst_y,
  output logic [0:FLIT_W-1] noc_data,
  output logic              noc_valid,
  output logic              noc_vch,
  output logic [1:0]        noc_lck,
  input  logic [1:0]        noc_ack,
  output logic              err_credit
);

  ni_state_t          state, state_nx;
  logic               vc, vc_nx;
  logic               rr_ptr, rr_nx;
  logic [1:0]         dst_x, dst_x_nx;
  logic [1:0]         dst_y, dst_y_nx;
  logic [CW-1:0]      credit [NUM_VC];
  logic [NUM_VC-1:0]  has_credit;
  logic [NUM_VC-1:0]  dec;
  logic [NUM_VC-1:0]  ovf;
  logic               send;
  logic               send_head;
  logic [0:FLIT_W-1]  flit;
  logic [1:0]         lck_nx;

  for (genvar v = 0; v < NUM_VC; v++) begin : gen_vc
    ni_credit_counter #(
      .BUF_DEPTH (BUF_DEPTH),
      .CW        (CW)
    ) u_cnt (
      .clk      (clk),
      .rst_     (rst_),
      .dec      (dec[v]),
      .inc      (noc_ack[v]),
      .count    (credit[v]),
      .overflow (ovf[v])
    );
    assign has_credit[v] = (credit[v] != '0);
    assign dec[v]        = send && (vc == v[0]);
  end

  assign err_credit = |ovf;

  always_comb begin
    state_nx  = state;
    vc_nx     = vc;
    rr_nx     = rr_ptr;
    dst_x_nx  = dst_x;
    dst_y_nx  = dst_y;
    tx_ready  = 1'b0;
    send      = 1'b0;
    send_head = 1'b0;
    flit      = '0;
    case (state)
      ST_IDLE: begin
        if (tx_valid && (has_credit[rr_ptr] || has_credit[~rr_ptr])) begin
          vc_nx    = has_credit[rr_ptr] ? rr_ptr : ~rr_ptr;
          rr_nx    = ~rr_ptr;
          dst_x_nx = tx_dst_x;
          dst_y_nx = tx_dst_y;
          state_nx = ST_HEAD;
        end
      end
      ST_HEAD: begin
        if (has_credit[vc]) begin
          send      = 1'b1;
          send_head = 1'b1;
          flit[TYPE_OFS  +: 2] = FT_HEAD;
          flit[DST_X_OFS +: 2] = dst_x;
          flit[DST_Y_OFS +: 2] = dst_y;
          flit[SRC_X_OFS +: 2] = my_xpos;
          flit[SRC_Y_OFS +: 2] = my_ypos;
          state_nx  = ST_DATA;
        end
      end
      ST_DATA: begin
        // Words offered while reset is asserted must not be taken
        tx_ready = has_credit[vc] && !rst_;
        if (tx_valid && tx_ready) begin
          send = 1'b1;
          flit[TYPE_OFS +: 2]  = tx_last ? FT_TAIL : FT_BODY;
          flit[DATA_OFS +: 32] = tx_data;
          if (tx_last) state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Lock covers the head output cycle through the tail output cycle
  assign lck_nx = (state == ST_DATA || send_head) ? (2'b01 << vc) : 2'b00;

  always_ff @(posedge clk) begin
    if (rst_) begin
      state     <= ST_IDLE;
      vc        <= 1'b0;
      rr_ptr    <= 1'b0;
      dst_x     <= '0;
      dst_y     <= '0;
      noc_data  <= '0;
      noc_valid <= 1'b0;
      noc_vch   <= 1'b0;
      noc_lck   <= '0;
    end else begin
      state     <= state_nx;
      vc        <= vc_nx;
      rr_ptr    <= rr_nx;
      dst_x     <= dst_x_nx;
      dst_y     <= dst_y_nx;
      noc_valid <= send;
      noc_lck   <= lck_nx;
      if (send) begin
        noc_data <= flit;
        noc_vch  <= vc;
      end
    end
  end

endmodule

// File: tb/tb_noc_inject_ni.sv
// Scoreboard bench for noc_inject_ni: directed packets push expected flits,
// a negedge monitor pops and compares every flit the NI emits.
module tb_noc_inject_ni;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [1:0]  my_xpos = 2'd1;
  logic [1:0]  my_ypos = 2'd2;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] tx_data = '0;
  logic        tx_last = 1'b0;
  logic [1:0]  tx_dst_x = '0;
  logic [1:0]  tx_dst_y = '0;
  logic [0:34] noc_data;
  logic        noc_valid;
  logic        noc_vch;
  logic [1:0]  noc_lck;
  logic [1:0]  noc_ack = '0;
  logic        err_credit;

  typedef struct packed {
    logic [0:34] data;
    logic        vch;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nflits = 0;
  int   lck_cycles = 0;

  noc_inject_ni #(.BUF_DEPTH(4)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .my_xpos    (my_xpos),
    .my_ypos    (my_ypos),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .tx_dst_x   (tx_dst_x),
    .tx_dst_y   (tx_dst_y),
    .noc_data   (noc_data),
    .noc_valid  (noc_valid),
    .noc_vch    (noc_vch),
    .noc_lck    (noc_lck),
    .noc_ack    (noc_ack),
    .err_credit (err_credit)
  );

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (noc_lck != 2'b00) lck_cycles++;
    if (noc_valid) begin
      nflits++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flit: got data=%h vch=%0d, none expected", noc_data, noc_vch);
      end else begin
        e = exp_q.pop_front();
        if (noc_data !== e.data || noc_vch !== e.vch || noc_lck !== (2'b01 << e.vch)) begin
          errors++;
          $display("FAIL flit: got data=%h vch=%0d lck=%b, want data=%h vch=%0d lck=%b",
                   noc_data, noc_vch, noc_lck, e.data, e.vch, 2'b01 << e.vch);
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void push_head(input logic v, input logic [1:0] dx, input logic [1:0] dy);
    exp_t e;
    e.data = {2'b10, dx, dy, my_xpos, my_ypos, 25'd0};
    e.vch  = v;
    exp_q.push_back(e);
  endfunction

  function automatic void push_word(input logic v, input logic [31:0] d, input logic last);
    exp_t e;
    e.data = {last ? 2'b01 : 2'b00, 1'b0, d};
    e.vch  = v;
    exp_q.push_back(e);
  endfunction

  // Present one word and wait (bounded) for it to be taken; optional VC0 ack
  // is raised in the very cycle the word is accepted.
  task automatic send_word(input logic [31:0] d, input logic last,
                           input logic [1:0] dx, input logic [1:0] dy, input logic ack0);
    int n = 0;
    tx_valid = 1'b1; tx_data = d; tx_last = last; tx_dst_x = dx; tx_dst_y = dy;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_ready && n < 50);
    check("handshake", {63'd0, tx_ready}, 64'd1);
    if (ack0) noc_ack[0] = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    noc_ack  = 2'b00;
  endtask

  task automatic ack_pulse(input int v);
    noc_ack[v] = 1'b1;
    @(posedge clk); #1;
    noc_ack = 2'b00;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    tx_valid = 1'b0;
    noc_ack = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1 check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int base;

    // Reset state
    do_reset();
    check("rst_valid", {63'd0, noc_valid}, 64'd0);
    check("rst_lck", {62'd0, noc_lck}, 64'd0);
    check("rst_err", {63'd0, err_credit}, 64'd0);
    check("rst_ready", {63'd0, tx_ready}, 64'd0);
    check("rst_data", {29'd0, noc_data}, 64'd0);

    // Single-word packet: head 10_10_00_01_10 then tail DEADBEEF on VC0
    base = lck_cycles;
    push_head(1'b0, 2'd2, 2'd0);
    push_word(1'b0, 32'hDEADBEEF, 1'b1);
    send_word(32'hDEADBEEF, 1'b1, 2'd2, 2'd0, 1'b0);
    drain("single_drain");
    check("single_lck_cycles", 64'(lck_cycles - base), 64'd2);

    // Credit exhaustion on VC0 with a 6-word packet
    do_reset();
    base = nflits;
    push_head(1'b0, 2'd3, 2'd1);
    for (int i = 1; i <= 6; i++) push_word(1'b0, 32'h1000_0000 + i, i == 6);
    for (int i = 1; i <= 3; i++) send_word(32'h1000_0000 + i, 1'b0, 2'd3, 2'd1, 1'b0);
    tx_valid = 1'b1; tx_data = 32'h1000_0004; tx_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("exhaust_ready_low", {63'd0, tx_ready}, 64'd0);
    end
    check("exhaust_flits", 64'(nflits - base), 64'd4);
    @(posedge clk); #1;
    ack_pulse(0);
    send_word(32'h1000_0004, 1'b0, 2'd3, 2'd1, 1'b0);
    tx_valid = 1'b1; tx_data = 32'h1000_0005;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("exhaust_one_only", {63'd0, tx_ready}, 64'd0);
    end
    check("exhaust_flits_after_ack", 64'(nflits - base), 64'd5);
    @(posedge clk); #1;
    ack_pulse(0);
    send_word(32'h1000_0005, 1'b0, 2'd3, 2'd1, 1'b0);
    ack_pulse(0);
    send_word(32'h1000_0006, 1'b1, 2'd3, 2'd1, 1'b0);
    drain("exhaust_drain");

    // VC alternation and fallback
    do_reset();
    push_head(1'b0, 2'd1, 2'd1); push_word(1'b0, 32'hA0A0_0001, 1'b1);
    send_word(32'hA0A0_0001, 1'b1, 2'd1, 2'd1, 1'b0);
    push_head(1'b1, 2'd2, 2'd2); push_word(1'b1, 32'hA0A0_0002, 1'b1);
    send_word(32'hA0A0_0002, 1'b1, 2'd2, 2'd2, 1'b0);
    push_head(1'b0, 2'd0, 2'd3); push_word(1'b0, 32'hA0A0_0003, 1'b1);
    send_word(32'hA0A0_0003, 1'b1, 2'd0, 2'd3, 1'b0);
    push_head(1'b1, 2'd3, 2'd3); push_word(1'b1, 32'hA0A0_0004, 1'b1);
    send_word(32'hA0A0_0004, 1'b1, 2'd3, 2'd3, 1'b0);
    for (int i = 0; i < 4; i++) ack_pulse(0);
    push_head(1'b0, 2'd1, 2'd0); push_word(1'b0, 32'hA0A0_0005, 1'b1);
    send_word(32'hA0A0_0005, 1'b1, 2'd1, 2'd0, 1'b0);
    push_head(1'b0, 2'd0, 2'd1); push_word(1'b0, 32'hA0A0_0006, 1'b1);
    send_word(32'hA0A0_0006, 1'b1, 2'd0, 2'd1, 1'b0);
    drain("alt_drain");

    // Simultaneous ack and send, then spurious ack on VC1
    do_reset();
    push_head(1'b0, 2'd2, 2'd3);
    push_word(1'b0, 32'h5555_0001, 1'b0);
    push_word(1'b0, 32'h5555_0002, 1'b1);
    send_word(32'h5555_0001, 1'b0, 2'd2, 2'd3, 1'b1);
    send_word(32'h5555_0002, 1'b1, 2'd2, 2'd3, 1'b0);
    drain("simul_drain");
    check("simul_credit0", 64'(dut.gen_vc[0].u_cnt.count), 64'd2);
    check("simul_no_err", {63'd0, err_credit}, 64'd0);
    ack_pulse(1);
    check("spurious_err", {63'd0, err_credit}, 64'd1);
    check("spurious_credit1", 64'(dut.gen_vc[1].u_cnt.count), 64'd4);

    // Mid-packet reset after the second body flit
    do_reset();
    check("reset_clears_err", {63'd0, err_credit}, 64'd0);
    push_head(1'b0, 2'd1, 2'd3);
    push_word(1'b0, 32'hCAFE_0001, 1'b0);
    push_word(1'b0, 32'hCAFE_0002, 1'b0);
    send_word(32'hCAFE_0001, 1'b0, 2'd1, 2'd3, 1'b0);
    send_word(32'hCAFE_0002, 1'b0, 2'd1, 2'd3, 1'b0);
    rst_ = 1'b1;
    tx_valid = 1'b1; tx_data = 32'hCAFE_0003; tx_last = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {63'd0, tx_ready}, 64'd0);
    @(posedge clk); #1;
    check("rst_mid_valid", {63'd0, noc_valid}, 64'd0);
    check("rst_mid_lck", {62'd0, noc_lck}, 64'd0);
    check("rst_mid_data", {29'd0, noc_data}, 64'd0);
    check("rst_mid_vch", {63'd0, noc_vch}, 64'd0);
    tx_valid = 1'b0;
    @(posedge clk); #1 rst_ = 1'b0;
    drain("rst_mid_no_tail");
    check("rst_mid_credit0", 64'(dut.gen_vc[0].u_cnt.count), 64'd4);
    push_head(1'b0, 2'd3, 2'd0);
    push_word(1'b0, 32'hBEEF_0001, 1'b1);
    send_word(32'hBEEF_0001, 1'b1, 2'd3, 2'd0, 1'b0);
    drain("post_rst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
